// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//
// Single-step instruction sequencer driven by a mechanical push button.
// The raw button is synchronized and debounced. Each accepted press advances
// a three-phase counter (P0 -> P1 -> P2 -> P0). Leaving P2 also advances the
// program counter. The instruction word is reloaded from a 16x16 program
// memory only while the sequencer idles in P0. It is frozen for the three
// steps of one instruction, so the downstream stage sees a constant INS.
// An opcode of 4'hF presented in P0 halts the sequencer. Rewriting that word
// with a non-halt opcode resumes it.
//
// Parameters
//   DEB_CNT    consecutive cycles a synchronized level must differ from the
//              debounced level before it is accepted
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   btn_raw    raw step button (asynchronous, may bounce)
//   load_en    program memory write strobe
//   load_addr  program memory write address
//   load_data  program memory write data
//   INS        instruction presented to the downstream stage
//   step       one-cycle strobe to the downstream stage
//   phase      current sub-step of the instruction (0, 1, 2)
//   pc         program counter
//   halt       halt opcode presented in phase 0
// -----------------------------------------------------------------------------
module instr_sequencer #(
   parameter int DEB_CNT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_raw,
   input  logic        load_en,
   input  logic [3:0]  load_addr,
   input  logic [15:0] load_data,
   output logic [15:0] INS,
   output logic        step,
   output logic [1:0]  phase,
   output logic [3:0]  pc,
   output logic        halt
);

   localparam int CNT_W = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CNT - 1);

   typedef enum logic [1:0] {
      P0 = 2'd0,
      P1 = 2'd1,
      P2 = 2'd2
   } phase_t;

   phase_t             state;
   logic [15:0]        mem [16];
   logic               btn_sync_p0;
   logic               btn_sync_p1;
   logic               deb_lvl;
   logic [CNT_W-1:0]   deb_cnt;
   logic               press_vld_p2;
   logic               accept;

   // Program memory: written at any time, cleared by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 16; i++) begin
            mem[i] <= '0;
         end
      end else if (load_en) begin
         mem[load_addr] <= load_data;
      end
   end

   // Stage p0/p1: two-flop synchronizer for the asynchronous button.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_sync_p0 <= 1'b0;
         btn_sync_p1 <= 1'b0;
      end else begin
         btn_sync_p0 <= btn_raw;
         btn_sync_p1 <= btn_sync_p0;
      end
   end

   // Stage p2: debouncer. The counter tracks how long the synchronized level
   // has disagreed with the debounced level; any agreement restarts it. A
   // press is flagged for one cycle on the edge the debounced level rises,
   // which keeps running even while halted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         deb_lvl      <= 1'b0;
         deb_cnt      <= '0;
         press_vld_p2 <= 1'b0;
      end else if (btn_sync_p1 != deb_lvl) begin
         if (deb_cnt == CNT_LAST) begin
            deb_lvl      <= btn_sync_p1;
            deb_cnt      <= '0;
            press_vld_p2 <= btn_sync_p1;
         end else begin
            deb_cnt      <= deb_cnt + 1'b1;
            press_vld_p2 <= 1'b0;
         end
      end else begin
         deb_cnt      <= '0;
         press_vld_p2 <= 1'b0;
      end
   end

   // A press arriving while halted is dropped without any side effect.
   assign accept = press_vld_p2 && !halt;

   // Stage p3: phase FSM, program counter, step strobe and instruction latch.
   // INS keeps its value on the press that leaves P0, so a same-cycle write
   // to mem[pc] cannot disturb the instruction being executed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= P0;
         pc    <= '0;
         step  <= 1'b0;
         INS   <= '0;
      end else begin
         step <= accept;
         if (state == P0 && !accept) begin
            INS <= mem[pc];
         end
         if (accept) begin
            case (state)
               P0: state <= P1;
               P1: state <= P2;
               P2: begin
                  state <= P0;
                  pc    <= pc + 4'd1;
               end
               default: state <= P0;
            endcase
         end
      end
   end

   assign phase = state;
   assign halt  = (state == P0) && (INS[15:12] == 4'hF);

endmodule
